// File: rtl/guess_game_core_pkg.sv
// Shared types and constants for the guessing game: FSM states, result codes
// and the active-low seven-segment patterns used by the display path.
package guess_game_core_pkg;

  typedef enum logic [2:0] {
    ST_SET    = 3'd0,
    ST_GUESS  = 3'd1,
    ST_RESULT = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_LOW  = 2'd2;
  localparam logic [1:0] RES_HIGH = 2'd3;

  // Hex digit patterns, entry 0 in the least significant byte (0=C0 ... F=8E).
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_L     = 8'hC7;
  localparam logic [7:0] SEG_O     = 8'hC0;
  localparam logic [7:0] SEG_H     = 8'h89;
  localparam logic [7:0] SEG_I     = 8'hCF;

  function automatic logic [7:0] hex_seg(input logic [3:0] value);
    return SEG_HEX[value];
  endfunction

endpackage

// File: rtl/guess_game_core_seg_scanner.sv
// Time-multiplexed display scanner: enables one digit at a time for SCAN_DIV
// clocks and drives the segment pattern belonging to that digit.
module seg_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 25000
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_DIGITS-1:0][7:0] patterns,
  output logic [NUM_DIGITS-1:0]      anodes,
  output logic [7:0]                 cathods
);
  import guess_game_core_pkg::*;

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [CNT_W-1:0] count_reg;
  logic [IDX_W-1:0] idx_reg;

  // Slot counter, digit index and registered anode/cathode drive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
      idx_reg   <= '0;
      anodes    <= '1;
      cathods   <= SEG_BLANK;
    end else begin
      anodes  <= ~(NUM_DIGITS'(1) << idx_reg);
      cathods <= patterns[idx_reg];
      if (count_reg == CNT_W'(SCAN_DIV - 1)) begin
        count_reg <= '0;
        idx_reg   <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/guess_game_core.sv
// Two-player number guessing game: P1 sets a secret, P2 guesses with
// low/high feedback, limited guess count, and a multiplexed 7-seg display.
module guess_game_core #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_GUESSES = 15,
  parameter int SCAN_DIV    = 25000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DIGIT_W-1:0]    value_in,
  input  logic [NUM_DIGITS-1:0] digit_wr,
  input  logic                  player_sel,
  input  logic                  submit,
  output logic [1:0]            result,
  output logic [7:0]            guess_count,
  output logic                  win,
  output logic                  lose,
  output logic [NUM_DIGITS-1:0] anodes,
  output logic [7:0]            cathods
);
  import guess_game_core_pkg::*;

  typedef logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits_t;

  // Sampled inputs and their one-clock-old copies for edge detection.
  logic                  submit_s, submit_p;
  logic                  sel_s, sel_p;
  logic [NUM_DIGITS-1:0] wr_s, wr_p;
  logic [DIGIT_W-1:0]    value_s;

  state_t     state_reg, state_next;
  digits_t    entry_reg, entry_next;
  digits_t    secret_reg, secret_next;
  logic [1:0] result_reg, result_next;
  logic [7:0] count_reg, count_next;
  logic [7:0] count_inc;

  logic submit_rise, sel_rise, sel_fall, wr_rise, wr_single, write_ok;

  // Input sampling; every edge is evaluated on the registered copies.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      submit_s <= 1'b0;
      submit_p <= 1'b0;
      sel_s    <= 1'b0;
      sel_p    <= 1'b0;
      wr_s     <= '0;
      wr_p     <= '0;
      value_s  <= '0;
    end else begin
      submit_s <= submit;
      submit_p <= submit_s;
      sel_s    <= player_sel;
      sel_p    <= sel_s;
      wr_s     <= digit_wr;
      wr_p     <= wr_s;
      value_s  <= value_in;
    end
  end

  assign submit_rise = submit_s & ~submit_p;
  assign sel_rise    = sel_s & ~sel_p;
  assign sel_fall    = ~sel_s & sel_p;
  assign wr_rise     = |(wr_s & ~wr_p);
  // Exactly one button held: nonzero and a power of two.
  assign wr_single   = (wr_s != '0) && ((wr_s & (wr_s - NUM_DIGITS'(1))) == '0);
  // A submit edge in the same cycle always swallows the digit write.
  assign write_ok    = wr_rise & wr_single & ~submit_rise;
  assign count_inc   = (count_reg == 8'hFF) ? 8'hFF : count_reg + 8'd1;

  // Game state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_SET;
      entry_reg  <= '0;
      secret_reg <= '0;
      result_reg <= RES_NONE;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      entry_reg  <= entry_next;
      secret_reg <= secret_next;
      result_reg <= result_next;
      count_reg  <= count_next;
    end
  end

  // Next-state logic; a player_sel fall outranks submit in every playing state.
  always_comb begin
    state_next  = state_reg;
    entry_next  = entry_reg;
    secret_next = secret_reg;
    result_next = result_reg;
    count_next  = count_reg;
    case (state_reg)
      ST_SET: begin
        if (sel_rise) begin
          secret_next = entry_reg;
          entry_next  = '0;
          count_next  = '0;
          state_next  = ST_GUESS;
        end else if (write_ok) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_s[i]) entry_next[i] = value_s;
          end
        end
      end
      ST_GUESS: begin
        if (sel_fall) begin
          entry_next  = '0;
          result_next = RES_NONE;
          count_next  = '0;
          state_next  = ST_SET;
        end else if (submit_rise) begin
          count_next = count_inc;
          if (entry_reg == secret_reg) begin
            result_next = RES_WIN;
            state_next  = ST_WIN;
          end else if (count_inc == 8'(MAX_GUESSES)) begin
            state_next  = ST_LOSE;
          end else begin
            result_next = (entry_reg < secret_reg) ? RES_LOW : RES_HIGH;
            state_next  = ST_RESULT;
          end
        end else if (write_ok) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (wr_s[i]) entry_next[i] = value_s;
          end
        end
      end
      ST_RESULT, ST_WIN, ST_LOSE: begin
        if (sel_fall) begin
          entry_next  = '0;
          result_next = RES_NONE;
          count_next  = '0;
          state_next  = ST_SET;
        end else if (submit_rise && state_reg == ST_RESULT) begin
          result_next = RES_NONE;
          state_next  = ST_GUESS;
        end
      end
      default: state_next = ST_SET;
    endcase
  end

  assign result      = result_reg;
  assign guess_count = count_reg;
  assign win         = (state_reg == ST_WIN);
  assign lose        = (state_reg == ST_LOSE);

  // Per-digit segment pattern selected by the game state.
  logic [NUM_DIGITS-1:0][7:0] patterns;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [3:0] entry_hex, secret_hex, count_hex;
    logic [7:0] result_seg;

    assign entry_hex  = 4'(entry_reg[gi]);
    assign secret_hex = 4'(secret_reg[gi]);

    if (gi < 2) begin : g_cnt
      assign count_hex = count_reg[gi*4 +: 4];
    end else begin : g_cnt_zero
      assign count_hex = 4'd0;
    end

    if (gi == 0) begin : g_res_right
      assign result_seg = (result_reg == RES_LOW) ? SEG_O : SEG_I;
    end else if (gi == 1) begin : g_res_left
      assign result_seg = (result_reg == RES_LOW) ? SEG_L : SEG_H;
    end else begin : g_res_blank
      assign result_seg = SEG_BLANK;
    end

    assign patterns[gi] = (state_reg == ST_RESULT) ? result_seg :
                          (state_reg == ST_WIN)    ? hex_seg(count_hex) :
                          (state_reg == ST_LOSE)   ? hex_seg(secret_hex) :
                                                     hex_seg(entry_hex);
  end

  seg_scanner #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV)
  ) u_scanner (
    .clock   (clock),
    .reset_n (reset_n),
    .patterns(patterns),
    .anodes  (anodes),
    .cathods (cathods)
  );

endmodule

// File: tb/tb_guess_game_core.sv
// Self-checking bench: directed game scenarios plus random play, all checked
// against a behavioural game model kept in the bench.
module tb_guess_game_core;
  localparam int ND = 4;
  localparam int DW = 4;
  localparam int MG = 3;
  localparam int SD = 4;

  localparam int P_SET = 0, P_GUESS = 1, P_RES = 2, P_WIN = 3, P_LOSE = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] value_in;
  logic [ND-1:0] digit_wr;
  logic          player_sel;
  logic          submit;
  logic [1:0]    result;
  logic [7:0]    guess_count;
  logic          win, lose;
  logic [ND-1:0] anodes;
  logic [7:0]    cathods;

  always #5 clock = ~clock;

  guess_game_core #(
    .NUM_DIGITS(ND), .DIGIT_W(DW), .MAX_GUESSES(MG), .SCAN_DIV(SD)
  ) dut (
    .clock(clock), .reset_n(reset_n), .value_in(value_in), .digit_wr(digit_wr),
    .player_sel(player_sel), .submit(submit), .result(result),
    .guess_count(guess_count), .win(win), .lose(lose),
    .anodes(anodes), .cathods(cathods)
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: whole numbers for entry/secret, phase per game rules.
  int m_phase, m_entry, m_secret, m_count, m_result;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_reset();
    m_phase = P_SET; m_entry = 0; m_secret = 0; m_count = 0; m_result = 0;
  endtask

  task automatic do_write(input logic [3:0] mask, input int v);
    value_in = DW'(v);
    digit_wr = mask;
    tick(3);
    digit_wr = '0;
    tick(2);
    if ($countones(mask) == 1 && (m_phase == P_SET || m_phase == P_GUESS)) begin
      for (int i = 0; i < ND; i++)
        if (mask[i]) m_entry = (m_entry & ~(15 << (4*i))) | ((v & 15) << (4*i));
    end
    $display("[TB] write mask=%b val=%h model_entry=%04h", mask, v & 15, m_entry);
  endtask

  task automatic do_submit(input logic [3:0] mask, input int v);
    value_in = DW'(v);
    digit_wr = mask;
    submit   = 1'b1;
    tick(3);
    submit   = 1'b0;
    digit_wr = '0;
    tick(2);
    if (m_phase == P_GUESS) begin
      m_count = (m_count < 255) ? m_count + 1 : 255;
      if (m_entry == m_secret) begin
        m_result = 1; m_phase = P_WIN;
      end else if (m_count == MG) begin
        m_phase = P_LOSE;
      end else begin
        m_result = (m_entry < m_secret) ? 2 : 3; m_phase = P_RES;
      end
    end else if (m_phase == P_RES) begin
      m_result = 0; m_phase = P_GUESS;
    end
    $display("[TB] submit entry=%04h secret=%04h -> phase=%0d result=%0d count=%0d",
             m_entry, m_secret, m_phase, m_result, m_count);
  endtask

  task automatic set_sel(input logic b);
    logic prev;
    prev = player_sel;
    player_sel = b;
    tick(4);
    if (!prev && b && m_phase == P_SET) begin
      m_secret = m_entry; m_entry = 0; m_count = 0; m_phase = P_GUESS;
    end else if (prev && !b && m_phase != P_SET) begin
      m_entry = 0; m_result = 0; m_count = 0; m_phase = P_SET;
    end
    $display("[TB] player_sel=%0b -> phase=%0d secret=%04h", b, m_phase, m_secret);
  endtask

  task automatic enter(input int val);
    for (int i = 0; i < ND; i++) do_write(4'(1 << i), (val >> (4*i)) & 15);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_result"}, 32'(result), 32'(m_result));
    check({tag, "_count"}, 32'(guess_count), 32'(m_count));
    check({tag, "_win"}, 32'(win), 32'(m_phase == P_WIN));
    check({tag, "_lose"}, 32'(lose), 32'(m_phase == P_LOSE));
  endtask

  function automatic logic [7:0] exp_seg(input int i);
    case (m_phase)
      P_RES: begin
        if (i == 0) return (m_result == 2) ? 8'hC0 : 8'hCF;
        if (i == 1) return (m_result == 2) ? 8'hC7 : 8'h89;
        return 8'hFF;
      end
      P_WIN:   return (i < 2) ? seg_tab[(m_count >> (4*i)) & 15] : seg_tab[0];
      P_LOSE:  return seg_tab[(m_secret >> (4*i)) & 15];
      default: return seg_tab[(m_entry >> (4*i)) & 15];
    endcase
  endfunction

  task automatic check_display(input string tag);
    logic [7:0] cap [ND];
    logic [ND-1:0] sel;
    for (int i = 0; i < ND; i++) cap[i] = 8'h00;
    for (int c = 0; c < ND*SD + 4; c++) begin
      @(negedge clock);
      for (int i = 0; i < ND; i++) begin
        sel = ~(ND'(1) << i);
        if (anodes === sel) cap[i] = cathods;
      end
    end
    for (int i = 0; i < ND; i++)
      check($sformatf("%s_d%0d", tag, i), 32'(cap[i]), 32'(exp_seg(i)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_count"}, 32'(guess_count), 0);
    check({tag, "_win"}, 32'(win), 0);
    check({tag, "_lose"}, 32'(lose), 0);
    check({tag, "_anodes"}, 32'(anodes), 32'hF);
    check({tag, "_cathods"}, 32'(cathods), 32'hFF);
  endtask

  initial begin
    logic [3:0] scan_exp [5];
    int k;
    scan_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    reset_n = 1'b0; value_in = '0; digit_wr = '0; player_sel = 1'b0; submit = 1'b0;
    model_reset();
    tick(2);
    check_reset_outputs("rst");

    // Scanner stepping right after reset release.
    reset_n = 1'b1;
    k = 0;
    while (anodes === 4'hF && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("scan0", 32'(anodes), 32'(scan_exp[0]));
    tick(3);
    check("scan0_hold", 32'(anodes), 32'(scan_exp[0]));
    tick(1);
    for (int s = 1; s < 5; s++) begin
      check($sformatf("scan%0d", s), 32'(anodes), 32'(scan_exp[s]));
      tick(4);
    end
    check_display("rst_disp");

    // Correct first guess.
    enter(32'h1234); set_sel(1'b1);
    enter(32'h1234); do_submit(4'b0000, 0);
    check_state("win1");
    check("win1_flag", 32'(win), 1);
    check_display("win1_disp");
    set_sel(1'b0); check_state("win1_back");

    // Low then high feedback.
    enter(32'h1234); set_sel(1'b1);
    enter(32'h1200); do_submit(4'b0000, 0);
    check_state("low"); check_display("low_disp");
    do_submit(4'b0000, 0); check_state("low_ret");
    enter(32'h2000); do_submit(4'b0000, 0);
    check_state("high"); check_display("high_disp");
    set_sel(1'b0);

    // Out of guesses.
    enter(32'h00FF); set_sel(1'b1);
    enter(32'h0100); do_submit(4'b0000, 0); do_submit(4'b0000, 0);
    enter(32'h0000); do_submit(4'b0000, 0); do_submit(4'b0000, 0);
    enter(32'hFFFF); do_submit(4'b0000, 0);
    check_state("lose"); check("lose_flag", 32'(lose), 1);
    check_display("lose_disp");
    set_sel(1'b0); check_state("lose_back");

    // Multi-bit write ignored; submit beats a same-cycle write.
    enter(32'h5555); set_sel(1'b1);
    enter(32'h4444);
    do_write(4'b0101, 9); check_display("multi_disp");
    do_submit(4'b0001, 7); check_state("collide"); check_display("collide_disp");
    do_submit(4'b0000, 0); check_display("collide_entry");
    set_sel(1'b0);

    // Reset pulsed mid-game.
    enter(32'h0AB0); set_sel(1'b1); enter(32'h0123);
    reset_n = 1'b0;
    player_sel = 1'b0;
    tick(1);
    check_reset_outputs("midrst");
    model_reset();
    reset_n = 1'b1;
    tick(2);
    check_state("midrst_after"); check_display("midrst_disp");

    // Random play against the model.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 5))
        0: do_write(4'(1 << $urandom_range(0, 3)), int'($urandom_range(0, 15)));
        1: do_write(4'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        2: do_submit(4'b0000, 0);
        3: enter((m_phase == P_GUESS && $urandom_range(0, 1) == 1) ? m_secret
                                                                   : int'($urandom_range(0, 65535)));
        4: set_sel(~player_sel);
        default: do_submit(4'(1 << $urandom_range(0, 3)), int'($urandom_range(0, 15)));
      endcase
      check_state($sformatf("rnd%0d", n));
      if (n % 10 == 0) check_display($sformatf("rnd%0d_disp", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
